// File: rtl/ro_pkg.sv
// ---------------------------------------------------------------------------
// ro_pkg
// Shared definitions for the dual ring-oscillator sampling controller.
//   - ro_state_e     : sequencer states
//   - BYTE_W         : width of one delivered entropy byte
//   - SHIFT_DEPTH    : depth of the XOR shift register in the entropy buffer
//   - RO_PIPE_LAT    : register stages around the shift register (RO stage
//                      on the way in, output register on the way out)
//   - fillTimerLoad  : timer reload value used when entering FILL
// ---------------------------------------------------------------------------
package ro_pkg;

    localparam int BYTE_W        = 8;
    localparam int SHIFT_DEPTH   = 64;
    localparam int RO_PIPE_LAT   = 2;
    localparam int SEL_W         = $clog2(SHIFT_DEPTH / BYTE_W);
    localparam int TIMER_W       = 8;
    localparam int SAMPLE_PERIOD = BYTE_W;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        FILL,
        SAMPLE
    } ro_state_e;

    // The fill interval is 8*(sel+1) shifts plus the two pipeline stages.
    // The timer is loaded with one less than the interval because the cycle
    // in which it reads zero is itself part of the interval.
    function automatic logic [TIMER_W-1:0] fillTimerLoad(input logic [SEL_W-1:0] sel);
        return TIMER_W'(BYTE_W * (int'(sel) + 1) + RO_PIPE_LAT - 1);
    endfunction

endpackage

// File: rtl/ro_byte_holder.sv
// ---------------------------------------------------------------------------
// ro_byte_holder
// Single-entry holding register between the sampler and the consumer.
// A capture is accepted when the slot is empty or is being emptied in the
// same cycle; otherwise the byte is dropped and the sticky overrun flag set.
// Ports:
//   clk, rst_n    clock and asynchronous active-high reset
//   clear_i       clears the overrun flag (start of a new run)
//   capture_i     a fresh byte is available on byte_i this cycle
//   byte_i        byte to capture
//   ready_i       consumer ready
//   data_o        held byte
//   valid_o       held byte not yet consumed
//   overrun_o     sticky: a capture was dropped
//   handshake_o   valid_o && ready_i (a byte is consumed this cycle)
// ---------------------------------------------------------------------------
module ro_byte_holder
    import ro_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              capture_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              ready_i,
    output logic [BYTE_W-1:0] data_o,
    output logic              valid_o,
    output logic              overrun_o,
    output logic              handshake_o
);

    logic [BYTE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    assign handshake_o = valid_q & ready_i;

    // A coinciding handshake frees the slot, so the new byte may replace the
    // one being consumed without any bubble in data_valid.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (clear_i) begin
            overrun_d = 1'b0;
        end
        if (capture_i) begin
            if (!valid_q || handshake_o) begin
                data_d  = byte_i;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (handshake_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/ro_sample_ctrl.sv
// ---------------------------------------------------------------------------
// ro_sample_ctrl
// Sequencer for the dual ring-oscillator entropy buffer: enables the
// oscillators, waits out the warm-up, waits for the shift register to fill
// the selected byte window, then captures a non-overlapping byte every
// 8 cycles and hands it to the consumer over valid/ready.
// Parameters:
//   WARMUP_CYCLES  oscillator warm-up length in cycles (1..255)
// Ports:
//   clk, rst_n                       clock, asynchronous active-high reset
//   start_i, stop_i                  run start pulse / abort
//   sel_cfg_i, req_count_i           byte select and byte count (0 = endless)
//   byte_in_i                        registered byte from the entropy buffer
//   ro_activate_1_o, ro_activate_2_o oscillator enables
//   out_sel_o                        byte select to the buffer
//   data_out_o, data_valid_o         delivered byte and its valid
//   data_ready_i                     consumer ready
//   busy_o, overrun_o, done_o        status
// ---------------------------------------------------------------------------
module ro_sample_ctrl
    import ro_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [SEL_W-1:0]  sel_cfg_i,
    input  logic [7:0]        req_count_i,
    input  logic [BYTE_W-1:0] byte_in_i,
    output logic              ro_activate_1_o,
    output logic              ro_activate_2_o,
    output logic [SEL_W-1:0]  out_sel_o,
    output logic [BYTE_W-1:0] data_out_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              busy_o,
    output logic              overrun_o,
    output logic              done_o
);

    ro_state_e          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [7:0]         req_q, req_d;
    logic [7:0]         count_q, count_d;
    logic               ro_q, ro_d;
    logic               done_q, done_d;

    logic               capture;
    logic               clearOverrun;
    logic               handshake;
    logic [7:0]         countInc;

    assign countInc = count_q + 8'd1;

    // Timers count down to zero; the zero cycle performs the action. A
    // completing handshake or a stop overrides any capture in that cycle,
    // since the run is ending.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        sel_d        = sel_q;
        req_d        = req_q;
        count_d      = handshake ? countInc : count_q;
        done_d       = 1'b0;
        capture      = 1'b0;
        clearOverrun = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    state_d      = WARMUP;
                    sel_d        = sel_cfg_i;
                    req_d        = req_count_i;
                    count_d      = '0;
                    clearOverrun = 1'b1;
                    timer_d      = TIMER_W'(WARMUP_CYCLES - 1);
                end
            end
            WARMUP: begin
                if (timer_q == '0) begin
                    state_d = FILL;
                    timer_d = fillTimerLoad(sel_q);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            FILL: begin
                if (timer_q == '0) begin
                    capture = 1'b1;
                    state_d = SAMPLE;
                    timer_d = TIMER_W'(SAMPLE_PERIOD - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            SAMPLE: begin
                if (timer_q == '0) begin
                    capture = 1'b1;
                    timer_d = TIMER_W'(SAMPLE_PERIOD - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion only counts while a run is active; a byte retained
        // from an aborted run that drains in IDLE never pulses done.
        if (state_q != IDLE && handshake && req_q != '0 && countInc == req_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
            timer_d = '0;
            capture = 1'b0;
        end

        if (state_q != IDLE && stop_i) begin
            done_d  = 1'b0;
            state_d = IDLE;
            timer_d = '0;
            capture = 1'b0;
        end

        ro_d = (state_d != IDLE);
    end

    // Oscillator enable is registered from the next state so it switches on
    // the same edge as the state and never glitches.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            sel_q   <= '0;
            req_q   <= '0;
            count_q <= '0;
            ro_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            count_q <= count_d;
            ro_q    <= ro_d;
            done_q  <= done_d;
        end
    end

    ro_byte_holder u_holder (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clearOverrun),
        .capture_i   (capture),
        .byte_i      (byte_in_i),
        .ready_i     (data_ready_i),
        .data_o      (data_out_o),
        .valid_o     (data_valid_o),
        .overrun_o   (overrun_o),
        .handshake_o (handshake)
    );

    assign ro_activate_1_o = ro_q;
    assign ro_activate_2_o = ro_q;
    assign out_sel_o       = sel_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;

endmodule
